// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared types and helpers for the byte -> Hamming(7,4) streaming encoder.
//   state_e       : controller states (IDLE / SEND0 / SEND1)
//   CW_W          : codeword width, 7 bits, or 8 when HAMMING_SECDED_EN is
//                   defined (adds an overall even-parity bit for SECDED)
//   ham74_parity  : returns {p4,p2,p1} for a data nibble (even parity)
// Configuration macro: HAMMING_SECDED_EN
// ---------------------------------------------------------------------------
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_e;

`ifdef HAMMING_SECDED_EN
    localparam int CW_W = 8;
`else
    localparam int CW_W = 7;
`endif

    function automatic logic [2:0] ham74_parity(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {p4, p2, p1};
    endfunction

endpackage

// File: rtl/ham74_enc.sv
// ---------------------------------------------------------------------------
// ham74_enc
// Purely combinational nibble -> Hamming(7,4) codeword encoder.
//   nib_i [3:0]       : data nibble d[3:0]
//   cw_o  [CW_W-1:0]  : {d3,d2,d1,p4,d0,p2,p1}; with HAMMING_SECDED_EN the
//                       MSB is the XOR of the seven lower bits.
// Configuration macro: HAMMING_SECDED_EN
// ---------------------------------------------------------------------------
module ham74_enc
    import hamming_pkg::*;
(
    input  logic [3:0]      nib_i,
    output logic [CW_W-1:0] cw_o
);

    logic [2:0] par;
    logic [6:0] base_cw;

    assign par     = ham74_parity(nib_i);
    assign base_cw = {nib_i[3], nib_i[2], nib_i[1], par[2], nib_i[0], par[1], par[0]};

`ifdef HAMMING_SECDED_EN
    // Overall parity makes the full 8-bit word even, enabling double-error detect.
    assign cw_o = {^base_cw, base_cw};
`else
    assign cw_o = base_cw;
`endif

endmodule

// File: rtl/hamming_byte_enc_ctrl.sv
// ---------------------------------------------------------------------------
// hamming_byte_enc_ctrl
// Accepts bytes on a valid/ready input, splits each into two nibbles, encodes
// each with Hamming(7,4) and emits the two codewords in order on a registered
// valid/ready output.
// Parameters:
//   LSN_FIRST : 1 = low nibble first, 0 = high nibble first
//   CNT_W     : width of the completed-byte counter
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : byte input handshake
//   cw_valid/cw_data/cw_last/cw_ready : codeword output handshake,
//                          cw_last marks the second codeword of a byte
//   byte_cnt             : bytes fully emitted, wraps silently
// Configuration macro: HAMMING_SECDED_EN (8-bit SECDED codewords)
// ---------------------------------------------------------------------------
module hamming_byte_enc_ctrl
    import hamming_pkg::*;
#(
    parameter int LSN_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cw_valid,
    output logic [CW_W-1:0]  cw_data,
    output logic             cw_last,
    input  logic             cw_ready,
    output logic [CNT_W-1:0] byte_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic [3:0]        nib1_q;
    logic [CW_W-1:0]   cw_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic              load_cw1;
    logic              cnt_inc;
    logic              use_held_nib;
    logic [3:0]        first_nib_in;
    logic [3:0]        second_nib_in;
    logic [3:0]        enc_nib;
    logic [CW_W-1:0]   enc_cw;

    assign first_nib_in  = (LSN_FIRST != 0) ? in_data[3:0] : in_data[7:4];
    assign second_nib_in = (LSN_FIRST != 0) ? in_data[7:4] : in_data[3:0];

    // One shared encoder: the held second nibble while in SEND0, otherwise
    // the first nibble of whatever byte is being offered.
    assign enc_nib = use_held_nib ? nib1_q : first_nib_in;

    ham74_enc u_enc (
        .nib_i (enc_nib),
        .cw_o  (enc_cw)
    );

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SEND0;
            SEND0:   if (cw_ready) state_d = SEND1;
            SEND1:   if (cw_ready) state_d = in_valid ? SEND0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready     = 1'b0;
        cw_valid     = 1'b0;
        cw_last      = 1'b0;
        load_cw1     = 1'b0;
        cnt_inc      = 1'b0;
        use_held_nib = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
            end
            SEND0: begin
                cw_valid     = 1'b1;
                use_held_nib = 1'b1;
                load_cw1     = cw_ready;
            end
            SEND1: begin
                cw_valid = 1'b1;
                cw_last  = 1'b1;
                // Combinational ready lets a new byte overlap the final handshake.
                in_ready = cw_ready && !rst;
                cnt_inc  = cw_ready;
            end
            default: ;
        endcase
    end

    // Datapath: codeword holding register, second-nibble store, byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cw_q   <= '0;
            nib1_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                nib1_q <= second_nib_in;
                cw_q   <= enc_cw;
            end else if (load_cw1) begin
                cw_q   <= enc_cw;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cw_data  = cw_q;
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_hamming_byte_enc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hamming_byte_enc_ctrl
// Directed bench. Three DUT copies share one stimulus stream:
//   dut_a : LSN_FIRST=1, CNT_W=16
//   dut_b : LSN_FIRST=0, CNT_W=16
//   dut_c : LSN_FIRST=1, CNT_W=4
// Expected codewords are a hand-computed table (7-bit or SECDED variant).
// ---------------------------------------------------------------------------
module tb_hamming_byte_enc_ctrl;
    import hamming_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [7:0] in_data;
    logic cw_ready;

    logic            in_ready_a, cw_valid_a, cw_last_a;
    logic [CW_W-1:0] cw_data_a;
    logic [15:0]     byte_cnt_a;
    logic            in_ready_b, cw_valid_b, cw_last_b;
    logic [CW_W-1:0] cw_data_b;
    logic [15:0]     byte_cnt_b;
    logic            in_ready_c, cw_valid_c, cw_last_c;
    logic [CW_W-1:0] cw_data_c;
    logic [3:0]      byte_cnt_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] enc_tab [16];

    always #5 clk = ~clk;

    hamming_byte_enc_ctrl #(.LSN_FIRST(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .cw_valid(cw_valid_a), .cw_data(cw_data_a),
        .cw_last(cw_last_a), .cw_ready(cw_ready), .byte_cnt(byte_cnt_a)
    );

    hamming_byte_enc_ctrl #(.LSN_FIRST(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .cw_valid(cw_valid_b), .cw_data(cw_data_b),
        .cw_last(cw_last_b), .cw_ready(cw_ready), .byte_cnt(byte_cnt_b)
    );

    hamming_byte_enc_ctrl #(.LSN_FIRST(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .cw_valid(cw_valid_c), .cw_data(cw_data_c),
        .cw_last(cw_last_c), .cw_ready(cw_ready), .byte_cnt(byte_cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef HAMMING_SECDED_EN
        enc_tab = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                    8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};
`else
        enc_tab = '{8'h00, 8'h07, 8'h19, 8'h1E, 8'h2A, 8'h2D, 8'h33, 8'h34,
                    8'h4B, 8'h4C, 8'h52, 8'h55, 8'h61, 8'h66, 8'h78, 8'h7F};
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cw_ready = 1'b0;

        // ---- reset state
        tick();
        tick();
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 0);
        chk("rst_cw_valid", 32'(cw_valid_a), 0);
        chk("rst_cw_data",  32'(cw_data_a), 0);
        chk("rst_cw_last",  32'(cw_last_a), 0);
        chk("rst_byte_cnt", 32'(byte_cnt_a), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready_a), 1);

        // ---- byte 0xB5, both nibble orders
        in_valid = 1'b1; in_data = 8'hB5; cw_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        #1;
        chk("b5_cw0_valid", 32'(cw_valid_a), 1);
        chk("b5_cw0_data",  32'(cw_data_a), 32'(enc_tab[5]));
        chk("b5_cw0_last",  32'(cw_last_a), 0);
        chk("b5_send0_in_ready", 32'(in_ready_a), 0);
        chk("b5_msn_cw0",   32'(cw_data_b), 32'(enc_tab[11]));
        tick();
        #1;
        chk("b5_cw1_data",  32'(cw_data_a), 32'(enc_tab[11]));
        chk("b5_cw1_last",  32'(cw_last_a), 1);
        chk("b5_send1_in_ready", 32'(in_ready_a), 1);
        chk("b5_msn_cw1",   32'(cw_data_b), 32'(enc_tab[5]));
        chk("b5_cnt_before", 32'(byte_cnt_a), 0);
        tick();
        #1;
        chk("b5_idle_valid", 32'(cw_valid_a), 0);
        chk("b5_byte_cnt",   32'(byte_cnt_a), 1);
        $display("txn byte=b5 done byte_cnt=%0d", byte_cnt_a);

        // ---- 0x01 then 0xFF back-to-back (accept during SEND1)
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_data = 8'hFF;
        #1;
        chk("x01_cw0", 32'(cw_data_a), 32'(enc_tab[1]));
        chk("x01_msn_cw0", 32'(cw_data_b), 32'(enc_tab[0]));
        tick();
        #1;
        chk("x01_cw1", 32'(cw_data_a), 32'(enc_tab[0]));
        chk("x01_cw1_last", 32'(cw_last_a), 1);
        chk("x01_overlap_ready", 32'(in_ready_a), 1);
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        #1;
        chk("xff_cw0", 32'(cw_data_a), 32'(enc_tab[15]));
        chk("xff_cw0_last", 32'(cw_last_a), 0);
        chk("x01_byte_cnt", 32'(byte_cnt_a), 2);
        tick();
        #1;
        chk("xff_cw1", 32'(cw_data_a), 32'(enc_tab[15]));
        tick();
        #1;
        chk("xff_idle_valid", 32'(cw_valid_a), 0);
        chk("xff_byte_cnt", 32'(byte_cnt_a), 3);
        $display("txn bytes=01,ff done byte_cnt=%0d", byte_cnt_a);

        // ---- back-pressure in SEND0 for 5 cycles; in_data changes ignored
        in_valid = 1'b1; in_data = 8'h3C; cw_ready = 1'b0;
        tick();
        in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid",    32'(cw_valid_a), 1);
            chk("stall_data",     32'(cw_data_a), 32'(enc_tab[12]));
            chk("stall_last",     32'(cw_last_a), 0);
            chk("stall_in_ready", 32'(in_ready_a), 0);
            chk("stall_byte_cnt", 32'(byte_cnt_a), 3);
            tick();
        end
        in_valid = 1'b0; cw_ready = 1'b1;
        tick();
        #1;
        chk("stall_cw1_data", 32'(cw_data_a), 32'(enc_tab[3]));
        chk("stall_cw1_last", 32'(cw_last_a), 1);
        // stall in SEND1 too: in_ready follows cw_ready
        cw_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        #1;
        chk("send1_stall_in_ready", 32'(in_ready_a), 0);
        tick();
        #1;
        chk("send1_stall_data", 32'(cw_data_a), 32'(enc_tab[3]));
        chk("send1_stall_cnt",  32'(byte_cnt_a), 3);
        in_valid = 1'b0; cw_ready = 1'b1;
        tick();
        #1;
        chk("stall_done_cnt", 32'(byte_cnt_a), 4);
        $display("txn byte=3c stalled done byte_cnt=%0d", byte_cnt_a);

        // ---- reset, then stream 0x00..0x0F at full rate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h00; cw_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 15) in_valid = 1'b0;
            else in_data = 8'(i + 1);
            #1;
            chk("strm_cw0_valid", 32'(cw_valid_a), 1);
            chk("strm_cw0_data",  32'(cw_data_a), 32'(enc_tab[i]));
            chk("strm_cw0_last",  32'(cw_last_a), 0);
            tick();
            #1;
            chk("strm_cw1_valid", 32'(cw_valid_a), 1);
            chk("strm_cw1_data",  32'(cw_data_a), 32'(enc_tab[0]));
            chk("strm_cw1_last",  32'(cw_last_a), 1);
            chk("strm_msn_cw1",   32'(cw_data_b), 32'(enc_tab[i]));
            $display("txn stream byte=%02h cw0=%02h cw1=%02h", i, cw_data_a, cw_data_b);
        end
        tick();
        #1;
        chk("strm_idle_valid", 32'(cw_valid_a), 0);
        chk("strm_byte_cnt",   32'(byte_cnt_a), 16);
        chk("strm_wrap_cnt4",  32'(byte_cnt_c), 0);

        // ---- reset while in SEND1
        in_valid = 1'b1; in_data = 8'h5B;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("rst1_pre_data", 32'(cw_data_a), 32'(enc_tab[5]));
        chk("rst1_pre_last", 32'(cw_last_a), 1);
        rst = 1'b1;
        #1;
        chk("rst1_in_ready_during", 32'(in_ready_a), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst1_cw_valid", 32'(cw_valid_a), 0);
        chk("rst1_byte_cnt", 32'(byte_cnt_a), 0);
        chk("rst1_cw_data",  32'(cw_data_a), 0);
        chk("rst1_in_ready", 32'(in_ready_a), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("rst1_no_emit", 32'(cw_valid_a), 0);
        end
        $display("txn byte=5b interrupted by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
